// File: rtl/iq_pkg.sv
// iq_pkg: shared definitions for the instruction window front end.
//   - 8-bit instruction layout: [7:6] opcode, [5:4] src1, [3:2] src2, [1:0] dest
//   - opcode encodings, field LSB positions, window depth WIN
//   - win_state_t: window fill FSM states
//   - reg_field(): pull a 2-bit register/opcode field out of an instruction
package iq_pkg;

    localparam int WIN     = 4;
    localparam int INSTR_W = 8;

    localparam int OPC_LSB  = 6;
    localparam int SRC1_LSB = 4;
    localparam int SRC2_LSB = 2;
    localparam int DEST_LSB = 0;

    localparam logic [1:0] OPC_ALU0 = 2'b00;
    localparam logic [1:0] OPC_ALU1 = 2'b01;
    localparam logic [1:0] OPC_MUL  = 2'b10;
    localparam logic [1:0] OPC_DIV  = 2'b11;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ISSUE  = 2'd2,
        ST_CLEAR  = 2'd3
    } win_state_t;

    function automatic logic [1:0] reg_field(input logic [INSTR_W-1:0] instr, input int lsb);
        return instr[lsb +: 2];
    endfunction

endpackage

// File: rtl/raw_matrix_gen.sv
// raw_matrix_gen: combinational RAW dependence matrix for a WIN-slot window.
//   instr_flat : slot k instruction at [8k+7:8k]
//   valid_bits : slot occupancy
//   raw_flat   : bit WIN*j+i set when valid slot i reads a register written
//                by older valid slot j (j<i). Only true RAW hazards; WAR/WAW
//                are not reported, diagonal and j>=i bits are always 0.
module raw_matrix_gen
    import iq_pkg::*;
(
    input  logic [WIN*INSTR_W-1:0] instr_flat,
    input  logic [WIN-1:0]         valid_bits,
    output logic [WIN*WIN-1:0]     raw_flat
);

    // Opcodes and a few edge-slot fields never take part in the matrix.
    logic unused_fields;
    assign unused_fields = ^instr_flat;

    always_comb begin
        raw_flat = '0;
        for (int j = 0; j < WIN; j++) begin
            for (int i = 0; i < WIN; i++) begin
                if (j < i) begin
                    raw_flat[WIN*j+i] = valid_bits[j] && valid_bits[i] &&
                        ((reg_field(instr_flat[INSTR_W*j +: INSTR_W], DEST_LSB) ==
                          reg_field(instr_flat[INSTR_W*i +: INSTR_W], SRC1_LSB)) ||
                         (reg_field(instr_flat[INSTR_W*j +: INSTR_W], DEST_LSB) ==
                          reg_field(instr_flat[INSTR_W*i +: INSTR_W], SRC2_LSB)));
                end
            end
        end
    end

endmodule

// File: rtl/instr_window_fill.sv
// instr_window_fill: packs an instruction stream into a 4-slot program-ordered
// window, publishes its RAW matrix, holds it while the scheduler issues, and
// clears/refills once every valid slot has retired (or the window stalls).
//   clk, reset_n       : clock, asynchronous active-low reset
//   in_valid/in_ready  : upstream handshake; in_instr carries the instruction,
//                        in_last closes the window after its accept
//   instr_flat         : slot k at [8k+7:8k]
//   valid_bits         : slot occupancy
//   raw_flat           : bit 4j+i = slot i depends on older slot j
//   sch_enable         : window stable, scheduler may issue
//   sch_clear          : one-cycle scheduler reset between windows
//   retire_onehot      : completions from the scheduler
//   window_done        : one-cycle pulse with sch_clear
//   err_stall          : sticky, set when ISSUE sees STALL_LIMIT idle cycles
//   dbg_state          : current FSM state (win_state_t encoding)
//
// Handshake: an instruction transfers on a rising edge where in_valid and
// in_ready are both high; in_ready is registered and high for all of FILL,
// and in_instr/in_last are only looked at on a transfer.
module instr_window_fill
    import iq_pkg::*;
#(
    parameter int FILL_TIMEOUT = 8,
    parameter int STALL_LIMIT  = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_instr,
    input  logic        in_last,
    output logic [31:0] instr_flat,
    output logic [3:0]  valid_bits,
    output logic [15:0] raw_flat,
    output logic        sch_enable,
    output logic        sch_clear,
    input  logic [3:0]  retire_onehot,
    output logic        window_done,
    output logic        err_stall,
    output logic [1:0]  dbg_state
);

    localparam int IW = (FILL_TIMEOUT > 0) ? $clog2(FILL_TIMEOUT + 1) : 1;
    localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

    win_state_t             state_q, state_d;
    logic                   in_ready_q, in_ready_d;
    logic [WIN*INSTR_W-1:0] instr_q, instr_d;
    logic [WIN-1:0]         valid_q, valid_d;
    logic [WIN-1:0]         retired_q, retired_d;
    logic [WIN*WIN-1:0]     raw_q, raw_d, raw_next;
    logic [2:0]             count_q, count_d;
    logic [IW-1:0]          idle_q, idle_d;
    logic [SW-1:0]          stall_q, stall_d;
    logic                   sch_enable_q, sch_enable_d;
    logic                   sch_clear_q, sch_clear_d;
    logic                   window_done_q, window_done_d;
    logic                   err_q, err_d;
    logic                   accept;
    logic                   close_win;
    logic [WIN-1:0]         masked;

    assign accept = in_valid && in_ready_q;
    assign masked = retire_onehot & valid_q;

    // Window contents. Kept apart from the control block so the matrix
    // generator can look at the post-accept window without a comb loop.
    always_comb begin
        instr_d = instr_q;
        valid_d = valid_q;
        if (accept) begin
            instr_d[{count_q[1:0], 3'b000} +: INSTR_W] = in_instr;
            valid_d[count_q[1:0]] = 1'b1;
        end else if (state_q == ST_CLEAR) begin
            valid_d = '0;
        end
    end

    // Fed from the next-state window so raw_flat is already valid during
    // SETTLE, one cycle ahead of sch_enable.
    raw_matrix_gen u_raw_gen (
        .instr_flat (instr_d),
        .valid_bits (valid_d),
        .raw_flat   (raw_next)
    );

    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        raw_d         = raw_q;
        retired_d     = retired_q;
        count_d       = count_q;
        idle_d        = idle_q;
        stall_d       = stall_q;
        sch_enable_d  = sch_enable_q;
        sch_clear_d   = 1'b0;
        window_done_d = 1'b0;
        err_d         = err_q;
        close_win     = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    count_d   = count_q + 3'd1;
                    idle_d    = '0;
                    close_win = (count_d == 3'(WIN)) || in_last;
                end else if (count_q != 3'd0) begin
                    // An empty window never times out.
                    idle_d    = idle_q + 1'b1;
                    close_win = (FILL_TIMEOUT != 0) && (idle_d == IW'(FILL_TIMEOUT));
                end
                if (close_win) begin
                    state_d    = ST_SETTLE;
                    in_ready_d = 1'b0;
                    raw_d      = raw_next;
                end
            end
            ST_SETTLE: begin
                state_d      = ST_ISSUE;
                sch_enable_d = 1'b1;
                retired_d    = '0;
                stall_d      = '0;
            end
            ST_ISSUE: begin
                retired_d = retired_q | masked;
                stall_d   = (masked != '0) ? '0 : stall_q + 1'b1;
                // Checking the merged vector lets the final retire close the
                // window in the same cycle it arrives.
                if (retired_d == valid_q) begin
                    state_d       = ST_CLEAR;
                    sch_enable_d  = 1'b0;
                    sch_clear_d   = 1'b1;
                    window_done_d = 1'b1;
                end else if ((masked == '0) && (stall_d == SW'(STALL_LIMIT))) begin
                    state_d       = ST_CLEAR;
                    sch_enable_d  = 1'b0;
                    sch_clear_d   = 1'b1;
                    window_done_d = 1'b1;
                    err_d         = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_d    = ST_FILL;
                in_ready_d = 1'b1;
                raw_d      = '0;
                retired_d  = '0;
                count_d    = '0;
                idle_d     = '0;
                stall_d    = '0;
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_FILL;
            in_ready_q    <= 1'b1;
            instr_q       <= '0;
            valid_q       <= '0;
            retired_q     <= '0;
            raw_q         <= '0;
            count_q       <= '0;
            idle_q        <= '0;
            stall_q       <= '0;
            sch_enable_q  <= 1'b0;
            sch_clear_q   <= 1'b0;
            window_done_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
            retired_q     <= retired_d;
            raw_q         <= raw_d;
            count_q       <= count_d;
            idle_q        <= idle_d;
            stall_q       <= stall_d;
            sch_enable_q  <= sch_enable_d;
            sch_clear_q   <= sch_clear_d;
            window_done_q <= window_done_d;
            err_q         <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign instr_flat  = instr_q;
    assign valid_bits  = valid_q;
    assign raw_flat    = raw_q;
    assign sch_enable  = sch_enable_q;
    assign sch_clear   = sch_clear_q;
    assign window_done = window_done_q;
    assign err_stall   = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_window_fill.sv
// tb_instr_window_fill: directed and randomized windows checked against a
// transaction-level model of the window (fields decoded arithmetically,
// retire/stall bookkeeping per cycle).
module tb_instr_window_fill;

    localparam int FT = 8;
    localparam int SL = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_instr;
    logic        in_last;
    logic [31:0] instr_flat;
    logic [3:0]  valid_bits;
    logic [15:0] raw_flat;
    logic        sch_enable;
    logic        sch_clear;
    logic [3:0]  retire_onehot;
    logic        window_done;
    logic        err_stall;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [19:0] exp_q[$];    // {raw, valid} per filled window
    logic [3:0]  plan_q[$];   // directed retire vectors, consumed first
    logic [7:0]  m_instr[4];
    logic [3:0]  m_valid;
    logic [15:0] m_raw;
    logic        m_err;

    instr_window_fill #(.FILL_TIMEOUT(FT), .STALL_LIMIT(SL)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_last       (in_last),
        .instr_flat    (instr_flat),
        .valid_bits    (valid_bits),
        .raw_flat      (raw_flat),
        .sch_enable    (sch_enable),
        .sch_clear     (sch_clear),
        .retire_onehot (retire_onehot),
        .window_done   (window_done),
        .err_stall     (err_stall),
        .dbg_state     (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Dependence rule evaluated straight from the field definitions.
    function automatic logic [15:0] model_raw(input logic [7:0] ins[4], input logic [3:0] v);
        logic [15:0] r;
        int d, s1, s2;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < i; j++) begin
                d  = int'(ins[j]) % 4;
                s1 = (int'(ins[i]) / 16) % 4;
                s2 = (int'(ins[i]) / 4) % 4;
                if (v[i] && v[j] && (d == s1 || d == s2)) r[4*j+i] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_window(input string tag);
        check_eq({tag, "_valid"}, 32'(valid_bits), 32'(m_valid));
        check_eq({tag, "_raw"}, 32'(raw_flat), 32'(m_raw));
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k]) check_eq({tag, "_slot"}, 32'(instr_flat[8*k +: 8]), 32'(m_instr[k]));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Accepts n entries of m_instr, then follows the window through SETTLE
    // into its first ISSUE cycle.
    task automatic fill_window(input int n, input bit use_last, input int pre_max, input int max_gap);
        logic [19:0] e;
        int gap;
        m_valid = '0;
        for (int k = 0; k < n; k++) begin
            gap = (k == 0) ? $urandom_range(0, pre_max) : $urandom_range(0, max_gap);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                in_instr = 8'($urandom);
                check_eq("gap_ready", 32'(in_ready), 32'd1);
                tick();
            end
            in_valid = 1'b1;
            in_instr = m_instr[k];
            in_last  = use_last && (k == n - 1);
            check_eq("acc_ready", 32'(in_ready), 32'd1);
            check_eq("acc_state", 32'(dbg_state), 32'd0);
            tick();
            m_valid[k] = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_raw = model_raw(m_instr, m_valid);
        exp_q.push_back({m_raw, m_valid});
        if (n < 4 && !use_last) begin
            for (int c = 0; c < FT; c++) begin
                check_eq("tmo_wait_ready", 32'(in_ready), 32'd1);
                tick();
            end
        end
        e = exp_q.pop_front();
        check_eq("settle_state", 32'(dbg_state), 32'd1);
        check_eq("settle_ready", 32'(in_ready), 32'd0);
        check_eq("settle_enable", 32'(sch_enable), 32'd0);
        check_eq("settle_valid", 32'(valid_bits), 32'(e[3:0]));
        check_eq("settle_raw", 32'(raw_flat), 32'(e[19:4]));
        tick();
        check_eq("issue_enable", 32'(sch_enable), 32'd1);
        check_eq("issue_state", 32'(dbg_state), 32'd2);
    endtask

    // Drives retires until the model says the window ends, then checks the
    // CLEAR pulse and the return to FILL.
    task automatic issue_window(input bit starve);
        logic [3:0] r, masked, retired;
        int stall, cyc;
        bit done;
        retired = '0;
        stall = 0;
        cyc = 0;
        done = 1'b0;
        while (!done && cyc < 4 * SL) begin
            check_eq("iss_enable", 32'(sch_enable), 32'd1);
            check_eq("iss_clear", 32'(sch_clear), 32'd0);
            check_window("iss");
            if (plan_q.size() > 0) r = plan_q.pop_front();
            else if (starve)       r = 4'd0;
            else                   r = 4'($urandom_range(0, 15));
            retire_onehot = r;
            in_valid = 1'($urandom_range(0, 1));
            in_instr = 8'($urandom);
            masked  = r & m_valid;
            retired = retired | masked;
            if (masked != 4'd0) stall = 0;
            else                stall++;
            if (retired == m_valid) done = 1'b1;
            else if (stall == SL) begin
                done  = 1'b1;
                m_err = 1'b1;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        retire_onehot = 4'($urandom_range(0, 15));
        check_eq("clr_state", 32'(dbg_state), 32'd3);
        check_eq("clr_sch_clear", 32'(sch_clear), 32'd1);
        check_eq("clr_window_done", 32'(window_done), 32'd1);
        check_eq("clr_enable", 32'(sch_enable), 32'd0);
        check_eq("clr_ready", 32'(in_ready), 32'd0);
        check_eq("clr_err", 32'(err_stall), 32'(m_err));
        tick();
        retire_onehot = 4'd0;
        check_eq("refill_state", 32'(dbg_state), 32'd0);
        check_eq("refill_sch_clear", 32'(sch_clear), 32'd0);
        check_eq("refill_window_done", 32'(window_done), 32'd0);
        check_eq("refill_ready", 32'(in_ready), 32'd1);
        check_eq("refill_valid", 32'(valid_bits), 32'd0);
        check_eq("refill_raw", 32'(raw_flat), 32'd0);
        check_eq("refill_err", 32'(err_stall), 32'(m_err));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, 32'(in_ready), 32'd1);
        check_eq({tag, "_instr"}, instr_flat, 32'd0);
        check_eq({tag, "_valid"}, 32'(valid_bits), 32'd0);
        check_eq({tag, "_raw"}, 32'(raw_flat), 32'd0);
        check_eq({tag, "_enable"}, 32'(sch_enable), 32'd0);
        check_eq({tag, "_clear"}, 32'(sch_clear), 32'd0);
        check_eq({tag, "_done"}, 32'(window_done), 32'd0);
        check_eq({tag, "_err"}, 32'(err_stall), 32'd0);
        check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic random_instrs();
        for (int k = 0; k < 4; k++) m_instr[k] = 8'($urandom);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_instr = 8'd0;
        in_last = 1'b0;
        retire_onehot = 4'd0;
        m_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        tick();

        // Directed full window with a chain of RAW hazards.
        m_instr[0] = 8'h81; m_instr[1] = 8'h14; m_instr[2] = 8'h02; m_instr[3] = 8'hE3;
        fill_window(4, 1'b0, 0, 0);
        check_eq("raw_hand", 32'(raw_flat), 32'h0000_08C2);
        issue_window(1'b0);

        // Two entries closed by in_last.
        random_instrs();
        fill_window(2, 1'b1, 0, 2);
        check_eq("last_valid", 32'(valid_bits), 32'b0011);
        issue_window(1'b0);

        // Single entry closed by the idle timeout.
        random_instrs();
        fill_window(1, 1'b0, 0, 0);
        check_eq("tmo_valid", 32'(valid_bits), 32'b0001);
        issue_window(1'b0);

        // Three entries; retires trickle in, one with an invalid-slot bit.
        random_instrs();
        fill_window(3, 1'b1, 0, 1);
        plan_q.push_back(4'b0001);
        plan_q.push_back(4'b0000);
        plan_q.push_back(4'b0100);
        plan_q.push_back(4'b1010);
        issue_window(1'b0);

        // No retires at all: stall error, forced clear, sticky flag.
        random_instrs();
        fill_window(4, 1'b0, 0, 0);
        issue_window(1'b1);
        random_instrs();
        fill_window(2, 1'b1, 0, 0);
        issue_window(1'b0);

        // Reset in the middle of ISSUE.
        random_instrs();
        fill_window(4, 1'b0, 0, 0);
        retire_onehot = 4'b0001;
        tick();
        #3;
        reset_n = 1'b0;
        #1;
        m_err = 1'b0;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        retire_onehot = 4'd0;
        tick();
        check_eq("postrst_ready", 32'(in_ready), 32'd1);
        check_eq("postrst_err", 32'(err_stall), 32'd0);

        // Randomized windows, including long idle stretches on an empty window.
        for (int w = 0; w < 30; w++) begin
            random_instrs();
            fill_window($urandom_range(1, 4), 1'($urandom_range(0, 1)), 12, 3);
            issue_window(1'b0);
        end

        check_eq("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
